// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for a registered 2-bit-opcode ALU: issues accepted
// commands, captures the ALU result two cycles later and queues it in a result FIFO.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [1:0]       alu_op_code,
    output logic [3:0]       alu_A,
    output logic [3:0]       alu_B,
    input  logic [5:0]       alu_C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       res_data,
    output logic [1:0]       res_op,
    output logic [CNT_W-1:0] done_cnt,
    output logic             busy
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 6;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RES_W-1:0] data;
    } res_entry_t;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     pend_op_q, pend_op_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    done_q, done_d;
    logic                busy_q, busy_d;
    res_entry_t          mem_q [DEPTH];

    logic                accept;
    logic                push;
    logic                pop;

    // Accept only in IDLE with a free slot, so the later capture can never overflow.
    assign cmd_ready = (state_q == S_IDLE) && (fcnt_q < FCNT_W'(DEPTH));
    assign res_valid = (fcnt_q != '0);
    assign res_data  = mem_q[rd_ptr_q].data;
    assign res_op    = mem_q[rd_ptr_q].op;

    assign alu_op_code = op_q;
    assign alu_A       = a_q;
    assign alu_B       = b_q;
    assign done_cnt    = done_q;
    assign busy        = busy_q;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        pend_op_d = pend_op_q;
        done_d    = done_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fcnt_d    = fcnt_q;
        push      = 1'b0;
        accept    = cmd_valid && cmd_ready;
        pop       = res_valid && res_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_WAIT;
                    op_d      = cmd_op;
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    pend_op_d = cmd_op;
                end
            end
            S_WAIT: state_d = S_CAPT;
            S_CAPT: begin
                state_d = S_IDLE;
                push    = 1'b1;
                done_d  = done_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pend_op_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fcnt_q    <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pend_op_q <= pend_op_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fcnt_q    <= fcnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (push) begin
                mem_q[wr_ptr_q] <= res_entry_t'({pend_op_q, alu_C});
            end
        end
    end

endmodule
